// File: rtl/video_frame_capture.sv
// -----------------------------------------------------------------------------
// video_frame_capture
//
// Turns the raw VDP pixel stream (hs/vs/en/rgb) into a ready/valid stream of
// tagged pixels {rgb, x, y, sof, sol}. Whole frames are captured while
// capture_en is held, always starting at a vertical sync edge. A small FIFO
// absorbs consumer stalls. When the FIFO is full, further pixels are dropped
// and counted, so the VDP side is never back-pressured.
//
// Parameters
//   FIFO_DEPTH_LOG2  FIFO holds 2**FIFO_DEPTH_LOG2 entries
//   SYNC_ACTIVE_LOW  1: hs/vs are asserted when low, 0: asserted when high
//
// Ports
//   clk, reset          clk85m domain clock, synchronous active-high reset
//   capture_en          level request to capture whole frames
//   display_hs/vs/en    raw VDP syncs and data enable
//   display_r/g/b       raw VDP pixel colour
//   out_valid/out_ready ready/valid handshake on the FIFO head
//   out_pixel           {r,g,b}
//   out_x, out_y        pixel column, active line index
//   out_sof, out_sol    first pixel of frame, first pixel of line
//   capturing           high while a frame is being captured
//   frame_count         completed captured frames (wraps)
//   overflow_count      dropped pixels (saturates)
//   frame_crc           CRC-16-CCITT of the last captured frame
//
// Optional feature macro: VIDEO_FRAME_CAPTURE_CRC_EN
//   defined   - per-frame CRC-16-CCITT over r,g,b bytes of every pushed pixel
//   undefined - frame_crc is tied to 0 and no CRC logic exists
// -----------------------------------------------------------------------------
module video_frame_capture #(
    parameter int FIFO_DEPTH_LOG2 = 6,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        capture_en,
    input  logic        display_hs,
    input  logic        display_vs,
    input  logic        display_en,
    input  logic [7:0]  display_r,
    input  logic [7:0]  display_g,
    input  logic [7:0]  display_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_pixel,
    output logic [10:0] out_x,
    output logic [9:0]  out_y,
    output logic        out_sof,
    output logic        out_sol,
    output logic        capturing,
    output logic [15:0] frame_count,
    output logic [15:0] overflow_count,
    output logic [15:0] frame_crc
);

    localparam int DEPTH   = 2 ** FIFO_DEPTH_LOG2;
    localparam int ENTRY_W = 24 + 11 + 10 + 2;
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_FULL = DEPTH[FIFO_DEPTH_LOG2:0];
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_CAPTURE
    } state_t;

    // Input stage: syncs are stored in asserted-high form so that the rest of
    // the logic is polarity independent.
    logic        hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d, en_s1_q, en_s1_d;
    logic        hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d, en_s2_q, en_s2_d;
    logic [23:0] rgb_s1_q, rgb_s1_d;

    logic [10:0] x_q, x_d, x_cur;
    logic [9:0]  y_q, y_d, y_cur;
    logic        sof_pend_q, sof_pend_d, sol_pend_q, sol_pend_d;
    logic        sof_now, sol_now;
    logic        hs_edge, vs_edge, en_fall;

    state_t      state_q, state_d;
    logic        frame_done;
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] overflow_count_q, overflow_count_d;

    logic [ENTRY_W-1:0]         fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
    logic [ENTRY_W-1:0]         head_q, head_d, entry_new;
    logic                       push_req, push_ok, pop, full;

    always_comb begin
        hs_s1_d  = display_hs ^ SYNC_ACTIVE_LOW;
        vs_s1_d  = display_vs ^ SYNC_ACTIVE_LOW;
        en_s1_d  = display_en;
        rgb_s1_d = {display_r, display_g, display_b};
        hs_s2_d  = hs_s1_q;
        vs_s2_d  = vs_s1_q;
        en_s2_d  = en_s1_q;

        hs_edge = hs_s1_q & ~hs_s2_q;
        vs_edge = vs_s1_q & ~vs_s2_q;
        en_fall = ~en_s1_q & en_s2_q;

        // A sync edge clears the counter before the pixel of the same cycle
        // is tagged, so a pixel coinciding with the edge gets position 0.
        x_cur = hs_edge ? 11'd0 : x_q;
        y_cur = vs_edge ? 10'd0 : y_q;
        x_d   = (en_s1_q && (x_cur != 11'h7FF)) ? x_cur + 11'd1 : x_cur;
        y_d   = (en_fall && (y_cur != 10'h3FF)) ? y_cur + 10'd1 : y_cur;

        sof_now    = en_s1_q & (sof_pend_q | vs_edge);
        sol_now    = en_s1_q & (sol_pend_q | hs_edge);
        sof_pend_d = en_s1_q ? 1'b0 : (sof_pend_q | vs_edge);
        sol_pend_d = en_s1_q ? 1'b0 : (sol_pend_q | hs_edge);
    end

    // Capture control: a frame is only ever entered and left on a vs edge.
    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_en) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (!capture_en)  state_d = ST_IDLE;
                else if (vs_edge) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (vs_edge) begin
                    frame_done = 1'b1;
                    if (!capture_en) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        frame_count_d = frame_done ? frame_count_q + 16'd1 : frame_count_q;
    end

    // FIFO with a registered head. A full FIFO still accepts a push when the
    // head is popped in the same cycle.
    always_comb begin
        entry_new = {rgb_s1_q, x_cur, y_cur, sof_now, sol_now};
        push_req  = en_s1_q && (state_q == ST_CAPTURE);
        pop       = (count_q != '0) && out_ready;
        full      = (count_q == CNT_FULL);
        push_ok   = push_req && (!full || pop);

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) count_d = count_q + CNT_ONE;
        if (!push_ok && pop) count_d = count_q - CNT_ONE;

        // The slot being written this cycle becomes the head when it is the
        // only entry left; memory is not yet updated, so bypass it.
        if (count_d == '0)
            head_d = head_q;
        else if (push_ok && (wr_ptr_q == rd_ptr_d))
            head_d = entry_new;
        else
            head_d = fifo_mem[rd_ptr_d];

        overflow_count_d = overflow_count_q;
        if (push_req && !push_ok && (overflow_count_q != 16'hFFFF))
            overflow_count_d = overflow_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_s1_q          <= 1'b0;
            vs_s1_q          <= 1'b0;
            en_s1_q          <= 1'b0;
            hs_s2_q          <= 1'b0;
            vs_s2_q          <= 1'b0;
            en_s2_q          <= 1'b0;
            x_q              <= '0;
            y_q              <= '0;
            sof_pend_q       <= 1'b0;
            sol_pend_q       <= 1'b0;
            state_q          <= ST_IDLE;
            frame_count_q    <= '0;
            overflow_count_q <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            head_q           <= '0;
        end else begin
            hs_s1_q          <= hs_s1_d;
            vs_s1_q          <= vs_s1_d;
            en_s1_q          <= en_s1_d;
            hs_s2_q          <= hs_s2_d;
            vs_s2_q          <= vs_s2_d;
            en_s2_q          <= en_s2_d;
            x_q              <= x_d;
            y_q              <= y_d;
            sof_pend_q       <= sof_pend_d;
            sol_pend_q       <= sol_pend_d;
            state_q          <= state_d;
            frame_count_q    <= frame_count_d;
            overflow_count_q <= overflow_count_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            head_q           <= head_d;
        end
        rgb_s1_q <= rgb_s1_d;
        if (push_ok) fifo_mem[wr_ptr_q] <= entry_new;
    end

`ifdef VIDEO_FRAME_CAPTURE_CRC_EN
    // Bit-serial CRC-16-CCITT over 24 bits, MSB first (r, then g, then b).
    function automatic logic [15:0] crc16_step24(input logic [15:0] crc_in,
                                                 input logic [23:0] data);
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] crc_run_q, crc_run_d, frame_crc_q, frame_crc_d;

    // Dropped pixels are still part of the frame content, so the CRC follows
    // push requests rather than accepted pushes.
    always_comb begin
        crc_run_d   = crc_run_q;
        frame_crc_d = frame_crc_q;
        if ((state_q == ST_CAPTURE) && vs_edge) begin
            frame_crc_d = crc_run_q;
            crc_run_d   = 16'hFFFF;
        end
        if (push_req) crc_run_d = crc16_step24(crc_run_d, rgb_s1_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_run_q   <= 16'hFFFF;
            frame_crc_q <= '0;
        end else begin
            crc_run_q   <= crc_run_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`else
    assign frame_crc = 16'h0000;
`endif

    assign out_valid      = (count_q != '0);
    assign out_pixel      = head_q[46:23];
    assign out_x          = head_q[22:12];
    assign out_y          = head_q[11:2];
    assign out_sof        = head_q[1];
    assign out_sol        = head_q[0];
    assign capturing      = (state_q == ST_CAPTURE);
    assign frame_count    = frame_count_q;
    assign overflow_count = overflow_count_q;

endmodule

// File: tb/tb_video_frame_capture.sv
// Self-checking bench for video_frame_capture (default parameters:
// 64-entry FIFO, active-low syncs). Video timing is generated frame by frame;
// the reference model works on whole pixels tagged with their geometric
// position and on a queue standing in for the FIFO.
module tb_video_frame_capture;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset, capture_en;
    logic        display_hs, display_vs, display_en;
    logic [7:0]  display_r, display_g, display_b;
    logic        out_valid, out_ready;
    logic [23:0] out_pixel;
    logic [10:0] out_x;
    logic [9:0]  out_y;
    logic        out_sof, out_sol, capturing;
    logic [15:0] frame_count, overflow_count, frame_crc;

    always #5 clk = ~clk;

    video_frame_capture dut (
        .clk            (clk),
        .reset          (reset),
        .capture_en     (capture_en),
        .display_hs     (display_hs),
        .display_vs     (display_vs),
        .display_en     (display_en),
        .display_r      (display_r),
        .display_g      (display_g),
        .display_b      (display_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pixel      (out_pixel),
        .out_x          (out_x),
        .out_y          (out_y),
        .out_sof        (out_sof),
        .out_sol        (out_sol),
        .capturing      (capturing),
        .frame_count    (frame_count),
        .overflow_count (overflow_count),
        .frame_crc      (frame_crc)
    );

    typedef struct packed {
        logic [23:0] rgb;
        logic [10:0] x;
        logic [9:0]  y;
        logic        sof;
        logic        sol;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    ent_t        last_head;
    int          fc_m, ovf_m, pop_cnt;
    logic [15:0] crc_m, fcrc_m;
    bit          cap_m;
    bit          p_vs_start, p_en;
    ent_t        p_ent;

    int n_chk  = 0;
    int n_fail = 0;
    int ready_mode;   // 0 stall, 1 always ready, 2 random, 3 ready one cycle after en
    bit prev_en_drv;
    bit force_zero_rgb;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction

    task automatic model_advance(input bit vs_start, input bit en, input ent_t e);
        bit pop, accept;
        if (reset) begin
            q.delete();
            last_head  = '0;
            fc_m       = 0;
            ovf_m      = 0;
            crc_m      = 16'hFFFF;
            fcrc_m     = 16'h0000;
            cap_m      = 1'b0;
            p_vs_start = 1'b0;
            p_en       = 1'b0;
            p_ent      = '0;
            return;
        end
        pop    = (q.size() != 0) && out_ready;
        accept = 1'b0;
        if (p_vs_start) begin
            if (cap_m) begin
                fc_m = (fc_m + 1) % 65536;
`ifdef VIDEO_FRAME_CAPTURE_CRC_EN
                fcrc_m = crc_m;
`endif
            end
            crc_m = 16'hFFFF;
            cap_m = capture_en;
        end
        if (p_en && cap_m) begin
            crc_m  = crc_byte(crc_byte(crc_byte(crc_m, p_ent.rgb[23:16]), p_ent.rgb[15:8]), p_ent.rgb[7:0]);
            accept = (q.size() < DEPTH) || pop;
            if (!accept && ovf_m < 65535) ovf_m++;
        end
        if (pop) begin
            void'(q.pop_front());
            pop_cnt++;
        end
        if (accept) q.push_back(p_ent);
        if (q.size() != 0) last_head = q[0];
        p_vs_start = vs_start;
        p_en       = en;
        p_ent      = e;
    endtask

    task automatic compare();
        ent_t h;
        h = (q.size() != 0) ? q[0] : last_head;
        check("out_valid", out_valid, (q.size() != 0));
        check("out_pixel", out_pixel, h.rgb);
        check("out_x", out_x, h.x);
        check("out_y", out_y, h.y);
        check("out_sof", out_sof, h.sof);
        check("out_sol", out_sol, h.sol);
        check("capturing", capturing, cap_m);
        check("frame_count", frame_count, fc_m);
        check("overflow_count", overflow_count, ovf_m);
        check("frame_crc", frame_crc, fcrc_m);
    endtask

    // One clock: drive inputs, advance the model across the coming edge,
    // then compare at the falling edge.
    task automatic cyc(input bit hs_a, input bit vs_a, input bit en, input bit vs_start,
                       input logic [23:0] rgb, input int x, input int y);
        ent_t e;
        display_hs = ~hs_a;
        display_vs = ~vs_a;
        display_en = en;
        {display_r, display_g, display_b} = rgb;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = prev_en_drv;
        endcase
        prev_en_drv = en;
        e.rgb = rgb;
        e.x   = 11'(x);
        e.y   = 10'(y);
        e.sof = (x == 0) && (y == 0);
        e.sol = (x == 0);
        model_advance(vs_start, en, e);
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
    endtask

    task automatic send_vs();
        idle(2);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, (i == 0), 24'h0, 0, 0);
        idle(2);
    endtask

    task automatic send_lines(input int w, input int h, input int cap_line, input bit cap_val);
        for (int row = 0; row < h; row++) begin
            if (row == cap_line) capture_en = cap_val;
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
            idle(2);
            for (int col = 0; col < w; col++)
                cyc(1'b0, 1'b0, 1'b1, 1'b0, force_zero_rgb ? 24'h0 : 24'($urandom()), col, row);
            idle(2);
        end
    endtask

    initial begin
        int pc0, fc0;
        logic [15:0] crc_exp;
        reset = 1'b1; capture_en = 1'b0; out_ready = 1'b1;
        display_hs = 1'b1; display_vs = 1'b1; display_en = 1'b0;
        display_r = 8'h0; display_g = 8'h0; display_b = 8'h0;
        ready_mode = 1; prev_en_drv = 1'b0; force_zero_rgb = 1'b0; pop_cnt = 0;
        @(negedge clk);
        idle(3);
        reset = 1'b0;
        check("rst_valid", out_valid, 1'b0);
        check("rst_fc", frame_count, 16'd0);
        check("rst_ovf", overflow_count, 16'd0);
        check("rst_capturing", capturing, 1'b0);
        check("rst_crc", frame_crc, 16'd0);

        // Frame geometry: 4x3 frame, then capture_en drops before the next vs
        capture_en = 1'b1;
        idle(3);
        pc0 = pop_cnt;
        send_vs();
        check("t1_capturing", capturing, 1'b1);
        send_lines(4, 3, -1, 1'b0);
        capture_en = 1'b0;
        send_vs();
        idle(4);
        check("t1_pixels", pop_cnt - pc0, 12);
        check("t1_fc", frame_count, 16'd1);
        check("t1_idle", capturing, 1'b0);

        // Start only at a frame boundary
        pc0 = pop_cnt;
        send_vs();
        send_lines(4, 2, 1, 1'b1);
        check("t2_no_output", pop_cnt - pc0, 0);
        check("t2_not_capturing", capturing, 1'b0);
        send_vs();
        check("t2_capturing", capturing, 1'b1);
        ready_mode = 0;
        send_lines(3, 2, -1, 1'b0);
        check("t6_pre_valid", out_valid, 1'b1);

        // Reset mid-line
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 0, 0);
        idle(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom()), 0, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom()), 1, 0);
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom()), 2, 0);
        reset = 1'b0;
        check("t6_valid", out_valid, 1'b0);
        check("t6_fc", frame_count, 16'd0);
        check("t6_ovf", overflow_count, 16'd0);
        check("t6_capturing", capturing, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'($urandom()), 3, 0);
        idle(4);

        // Overflow: 70 pixels into a stalled 64-entry FIFO
        send_vs();
        send_lines(10, 7, -1, 1'b0);
        check("t3_ovf_model", ovf_m, 6);
        check("t3_ovf", overflow_count, 16'd6);
        check("t3_occupancy", q.size(), DEPTH);
        check("t3_valid", out_valid, 1'b1);

        // Full FIFO with a pop on every push cycle
        ready_mode = 3;
        send_vs();
        send_lines(8, 2, -1, 1'b0);
        check("t4_ovf", overflow_count, 16'd6);
        check("t4_occupancy", q.size(), DEPTH);
        check("t4_fc", frame_count, 16'd1);
        ready_mode = 1;
        idle(80);
        check("t4_drained", out_valid, 1'b0);

        // capture_en dropped mid-frame
        ready_mode = 2;
        send_vs();
        idle(20);
        pc0 = pop_cnt;
        fc0 = fc_m;
        send_lines(5, 4, 2, 1'b0);
        send_vs();
        ready_mode = 1;
        idle(20);
        check("t5_pixels", pop_cnt - pc0, 20);
        check("t5_idle", capturing, 1'b0);
        check("t5_fc", frame_count, 16'(fc0 + 1));

        // One-pixel black frame for the CRC
        capture_en = 1'b1;
        idle(3);
        send_vs();
        force_zero_rgb = 1'b1;
        send_lines(1, 1, -1, 1'b0);
        force_zero_rgb = 1'b0;
        send_vs();
`ifdef VIDEO_FRAME_CAPTURE_CRC_EN
        crc_exp = 16'hCC9C;
`else
        crc_exp = 16'h0000;
`endif
        check("t6_frame_crc", frame_crc, crc_exp);

        // Random frames, random back-pressure and capture requests
        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            int w, h;
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 5);
            send_vs();
            send_lines(w, h, $urandom_range(0, h), 1'($urandom_range(0, 1)));
        end
        send_vs();
        ready_mode = 1;
        idle(100);
        check("final_drained", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
